// File: rtl/offset_ram_array.sv
// offset_ram_array: per-column x / per-row y offset store for the tile-shift display path.
// One command port updates single entries or sweep-clears an axis; both read ports are combinational.
module offset_ram_array #(
    parameter int POS_W    = 4,
    parameter int OFF_W    = 4,
    parameter int OFF_MOD  = 16,
    parameter int SAT_MODE = 0,
    parameter int MOVE_W   = 16
) (
    input  logic              sysclk,
    input  logic              ram_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_axis,
    input  logic [1:0]        cmd_op,
    input  logic [POS_W-1:0]  cmd_pos,
    input  logic [OFF_W-1:0]  cmd_data,
    input  logic [POS_W-1:0]  offset_pos_x,
    input  logic [POS_W-1:0]  offset_pos_y,
    output logic [OFF_W-1:0]  offset_x,
    output logic [OFF_W-1:0]  offset_y,
    output logic              busy,
    output logic              all_zero,
    output logic [MOVE_W-1:0] move_count,
    output logic              reset_check
);
    // state | meaning
    // IDLE  | accepting inc/dec/load/clear commands
    // CLEAR | zeroing one entry of the latched axis per cycle; commands stall

    localparam int N = 1 << POS_W;
    localparam logic [OFF_W-1:0] MAX_V = OFF_W'(OFF_MOD - 1);

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_DEC = 2'b01;
    localparam logic [1:0] OP_LD  = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    generate
        if (POS_W < 1 || POS_W > 16 || OFF_W < 1 || OFF_MOD < 2 ||
            OFF_MOD > (1 << OFF_W) || MOVE_W < 1) begin : g_bad_params
            $error("offset_ram_array: illegal POS_W/OFF_W/OFF_MOD/MOVE_W combination");
        end
    endgenerate

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state;
    logic [OFF_W-1:0] x_mem [N];
    logic [OFF_W-1:0] y_mem [N];
    logic [POS_W-1:0] sweep_idx;
    logic             clr_axis;
    logic [OFF_W-1:0] cur_val;
    logic [OFF_W-1:0] wr_val;
    logic             any_set;
    logic             accept;

    assign cmd_ready   = (state == IDLE) && !ram_reset;
    assign accept      = cmd_valid && cmd_ready;
    assign reset_check = ram_reset;
    assign offset_x    = x_mem[offset_pos_x];
    assign offset_y    = y_mem[offset_pos_y];
    assign cur_val     = cmd_axis ? y_mem[cmd_pos] : x_mem[cmd_pos];

    always_comb begin
        wr_val = cur_val;
        case (cmd_op)
            OP_INC: begin
                if (cur_val == MAX_V) wr_val = (SAT_MODE != 0) ? MAX_V : '0;
                else                  wr_val = cur_val + 1'b1;
            end
            OP_DEC: begin
                if (cur_val == '0) wr_val = (SAT_MODE != 0) ? '0 : MAX_V;
                else               wr_val = cur_val - 1'b1;
            end
            OP_LD:   wr_val = (cmd_data > MAX_V) ? MAX_V : cmd_data;
            default: wr_val = cur_val;
        endcase
    end

    always_comb begin
        any_set = 1'b0;
        for (int i = 0; i < N; i++) begin
            any_set = any_set | (|x_mem[i]) | (|y_mem[i]);
        end
    end
    assign all_zero = !any_set;

    always_ff @(posedge sysclk) begin
        if (ram_reset) begin
            for (int i = 0; i < N; i++) begin
                x_mem[i] <= '0;
                y_mem[i] <= '0;
            end
            state      <= IDLE;
            busy       <= 1'b0;
            sweep_idx  <= '0;
            clr_axis   <= 1'b0;
            move_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_op == OP_CLR) begin
                            clr_axis  <= cmd_axis;
                            sweep_idx <= '0;
                            busy      <= 1'b1;
                            state     <= CLEAR;
                        end else begin
                            if (cmd_axis) y_mem[cmd_pos] <= wr_val;
                            else          x_mem[cmd_pos] <= wr_val;
                            // saturated inc/dec holds still count as moves
                            if (!cmd_op[1] && (move_count != '1))
                                move_count <= move_count + 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (clr_axis) y_mem[sweep_idx] <= '0;
                    else          x_mem[sweep_idx] <= '0;
                    sweep_idx <= sweep_idx + 1'b1;
                    if (&sweep_idx) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_offset_ram_array.sv
// Testbench for offset_ram_array: three parameterisations driven by shared stimulus,
// each compared to an arithmetic reference model of the offset tables and move counter.
module tb_offset_ram_array;
    logic       sysclk;
    logic       ram_reset;
    logic       cmd_valid;
    logic       cmd_axis;
    logic [1:0] cmd_op;
    logic [3:0] cmd_pos;
    logic [3:0] cmd_data;
    logic [3:0] offset_pos_x;
    logic [3:0] offset_pos_y;

    logic        rdy [3];
    logic        bsy [3];
    logic        az  [3];
    logic        rc  [3];
    logic [3:0]  ox  [3];
    logic [3:0]  oy  [3];
    logic [15:0] mc0, mc1;
    logic [2:0]  mc_m;
    logic [15:0] mcv [3];

    assign mcv[0] = mc0;
    assign mcv[1] = mc1;
    assign mcv[2] = {13'b0, mc_m};

    offset_ram_array dut_a (
        .sysclk(sysclk), .ram_reset(ram_reset), .cmd_valid(cmd_valid), .cmd_ready(rdy[0]),
        .cmd_axis(cmd_axis), .cmd_op(cmd_op), .cmd_pos(cmd_pos), .cmd_data(cmd_data),
        .offset_pos_x(offset_pos_x), .offset_pos_y(offset_pos_y),
        .offset_x(ox[0]), .offset_y(oy[0]), .busy(bsy[0]), .all_zero(az[0]),
        .move_count(mc0), .reset_check(rc[0]));

    offset_ram_array #(.SAT_MODE(1), .OFF_MOD(10)) dut_s (
        .sysclk(sysclk), .ram_reset(ram_reset), .cmd_valid(cmd_valid), .cmd_ready(rdy[1]),
        .cmd_axis(cmd_axis), .cmd_op(cmd_op), .cmd_pos(cmd_pos), .cmd_data(cmd_data),
        .offset_pos_x(offset_pos_x), .offset_pos_y(offset_pos_y),
        .offset_x(ox[1]), .offset_y(oy[1]), .busy(bsy[1]), .all_zero(az[1]),
        .move_count(mc1), .reset_check(rc[1]));

    offset_ram_array #(.MOVE_W(3)) dut_m (
        .sysclk(sysclk), .ram_reset(ram_reset), .cmd_valid(cmd_valid), .cmd_ready(rdy[2]),
        .cmd_axis(cmd_axis), .cmd_op(cmd_op), .cmd_pos(cmd_pos), .cmd_data(cmd_data),
        .offset_pos_x(offset_pos_x), .offset_pos_y(offset_pos_y),
        .offset_x(ox[2]), .offset_y(oy[2]), .busy(bsy[2]), .all_zero(az[2]),
        .move_count(mc_m), .reset_check(rc[2]));

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // reference model: modulus, saturation and counter ceiling per instance
    int mmod [3] = '{16, 10, 16};
    bit msat [3] = '{0, 1, 0};
    int mmax [3] = '{65535, 65535, 7};
    int mx [3][16];
    int my [3][16];
    int mcnt [3];
    int m_sweep = 0;
    bit m_axis = 0;

    int n_checks = 0;
    int n_fail = 0;

    function automatic int model_op(int v, int op, int d, int md, bit sat);
        if (op == 0) return sat ? ((v + 1 < md) ? v + 1 : v) : (v + 1) % md;
        if (op == 1) return sat ? ((v > 0) ? v - 1 : 0) : (v + md - 1) % md;
        return (d < md) ? d : md - 1;
    endfunction

    function automatic bit model_zero(int k);
        for (int i = 0; i < 16; i++) if (mx[k][i] != 0 || my[k][i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick();
        int v;
        @(posedge sysclk);
        if (ram_reset) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 16; i++) begin mx[k][i] = 0; my[k][i] = 0; end
                mcnt[k] = 0;
            end
            m_sweep = 0;
        end else if (m_sweep > 0) begin
            for (int k = 0; k < 3; k++) begin
                if (m_axis) my[k][16 - m_sweep] = 0;
                else        mx[k][16 - m_sweep] = 0;
            end
            m_sweep--;
        end else if (cmd_valid) begin
            if (cmd_op == 2'd3) begin
                m_axis  = cmd_axis;
                m_sweep = 16;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    v = cmd_axis ? my[k][cmd_pos] : mx[k][cmd_pos];
                    v = model_op(v, int'(cmd_op), int'(cmd_data), mmod[k], msat[k]);
                    if (cmd_axis) my[k][cmd_pos] = v;
                    else          mx[k][cmd_pos] = v;
                    if (cmd_op != 2'd2 && mcnt[k] < mmax[k]) mcnt[k]++;
                end
            end
        end
        #1;
    endtask

    task automatic set_cmd(input bit v, input bit a, input logic [1:0] o,
                           input logic [3:0] p, input logic [3:0] d);
        cmd_valid = v; cmd_axis = a; cmd_op = o; cmd_pos = p; cmd_data = d;
    endtask

    task automatic pulse_reset();
        cmd_valid = 1'b0;
        ram_reset = 1'b1;
        tick();
        ram_reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        ram_reset = 1'b1;
        cmd_valid = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rdy[k] !== 1'b0 || rc[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hold[%0d] ready=%b reset_check=%b, need 0/1", k, rdy[k], rc[k]);
            end
        end
        tick();
        ram_reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rdy[k] !== 1'b1 || bsy[k] !== 1'b0 || az[k] !== 1'b1 || mcv[k] !== 16'd0 || rc[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state[%0d] ready=%b busy=%b all_zero=%b moves=%0d rc=%b, need 1/0/1/0/0",
                         k, rdy[k], bsy[k], az[k], mcv[k], rc[k]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            offset_pos_x = 4'(i); offset_pos_y = 4'(i);
            #1;
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (ox[k] !== 4'd0 || oy[k] !== 4'd0) begin
                    n_fail++;
                    $display("FAIL reset_read[%0d] pos %0d x=%0d y=%0d, need 0", k, i, ox[k], oy[k]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        offset_pos_x = 4'd3; offset_pos_y = 4'd3;
        set_cmd(1, 1, 2'd0, 4'd3, 4'd0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_checks++;
            if (oy[0] !== 4'(i % 16)) begin
                n_fail++;
                $display("FAIL wrap_inc step %0d y[3]=%0d, need %0d", i, oy[0], i % 16);
            end
            for (int k = 1; k < 3; k++) begin
                n_checks++;
                if (oy[k] !== 4'(my[k][3])) begin
                    n_fail++;
                    $display("FAIL wrap_model[%0d] step %0d y[3]=%0d, need %0d", k, i, oy[k], my[k][3]);
                end
            end
        end
        set_cmd(1, 1, 2'd1, 4'd3, 4'd0);
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (oy[0] !== 4'd15 || mcv[0] !== 16'd17 || ox[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_dec y[3]=%0d moves=%0d x[3]=%0d, need 15/17/0", oy[0], mcv[0], ox[0]);
        end
        for (int i = 0; i < 16; i++) begin
            offset_pos_x = 4'(i); offset_pos_y = 4'(i);
            #1;
            n_checks++;
            if (ox[0] !== 4'd0 || (i != 3 && oy[0] !== 4'd0)) begin
                n_fail++;
                $display("FAIL wrap_others pos %0d x=%0d y=%0d, need 0", i, ox[0], oy[0]);
            end
        end
    endtask

    task automatic test_sat();
        pulse_reset();
        offset_pos_x = 4'd0;
        set_cmd(1, 0, 2'd1, 4'd0, 4'd0);
        tick();
        n_checks++;
        if (ox[1] !== 4'd0) begin
            n_fail++; $display("FAIL sat_dec x[0]=%0d, need 0", ox[1]);
        end
        set_cmd(1, 0, 2'd2, 4'd0, 4'd12);
        tick();
        n_checks++;
        if (ox[1] !== 4'd9) begin
            n_fail++; $display("FAIL sat_load x[0]=%0d, need 9", ox[1]);
        end
        set_cmd(1, 0, 2'd0, 4'd0, 4'd0);
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (ox[1] !== 4'd9 || mcv[1] !== 16'd2) begin
            n_fail++; $display("FAIL sat_inc x[0]=%0d moves=%0d, need 9/2", ox[1], mcv[1]);
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (ox[k] !== 4'(mx[k][0])) begin
                n_fail++; $display("FAIL sat_model[%0d] x[0]=%0d, need %0d", k, ox[k], mx[k][0]);
            end
        end
    endtask

    task automatic test_clear();
        pulse_reset();
        offset_pos_x = 4'd5; offset_pos_y = 4'd5;
        set_cmd(1, 0, 2'd2, 4'd5, 4'd7); tick();
        set_cmd(1, 1, 2'd2, 4'd5, 4'd4); tick();
        set_cmd(1, 0, 2'd3, 4'd0, 4'd0); tick();
        set_cmd(1, 1, 2'd0, 4'd2, 4'd0);
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (bsy[k] !== 1'b1 || rdy[k] !== 1'b0 || ox[k] !== 4'(mx[k][5])) begin
                    n_fail++;
                    $display("FAIL clear_sweep[%0d] cyc %0d busy=%b ready=%b x[5]=%0d, need 1/0/%0d",
                             k, c, bsy[k], rdy[k], ox[k], mx[k][5]);
                end
            end
            tick();
        end
        n_checks++;
        if (bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            n_fail++; $display("FAIL clear_end busy=%b ready=%b, need 0/1", bsy[0], rdy[0]);
        end
        tick();
        cmd_valid = 1'b0;
        offset_pos_y = 4'd2;
        #1;
        n_checks++;
        if (oy[0] !== 4'd1 || mcv[0] !== 16'd1) begin
            n_fail++; $display("FAIL clear_held_cmd y[2]=%0d moves=%0d, need 1/1", oy[0], mcv[0]);
        end
        offset_pos_y = 4'd5;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (ox[k] !== 4'd0 || oy[k] !== 4'd4 || az[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_result[%0d] x[5]=%0d y[5]=%0d all_zero=%b, need 0/4/0", k, ox[k], oy[k], az[k]);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        pulse_reset();
        set_cmd(1, 0, 2'd2, 4'd3, 4'd5); tick();
        set_cmd(1, 1, 2'd2, 4'd7, 4'd2); tick();
        set_cmd(1, 0, 2'd2, 4'd12, 4'd9); tick();
        set_cmd(1, 1, 2'd3, 4'd0, 4'd0); tick();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 5; c++) tick();
        ram_reset = 1'b1;
        tick();
        ram_reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (bsy[k] !== 1'b0 || rdy[k] !== 1'b1 || az[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL midreset_state[%0d] busy=%b ready=%b all_zero=%b, need 0/1/1", k, bsy[k], rdy[k], az[k]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            offset_pos_x = 4'(i); offset_pos_y = 4'(i);
            #1;
            n_checks++;
            if (ox[0] !== 4'd0 || oy[0] !== 4'd0) begin
                n_fail++; $display("FAIL midreset_read pos %0d x=%0d y=%0d, need 0", i, ox[0], oy[0]);
            end
        end
    endtask

    task automatic test_move_sat();
        pulse_reset();
        offset_pos_x = 4'd1;
        set_cmd(1, 0, 2'd0, 4'd1, 4'd0);
        for (int i = 1; i <= 9; i++) begin
            #1;
            n_checks++;
            if (ox[2] !== 4'(i - 1)) begin
                n_fail++; $display("FAIL rdw_old step %0d x[1]=%0d, need %0d", i, ox[2], i - 1);
            end
            tick();
            n_checks++;
            if (ox[2] !== 4'(i) || mcv[2] !== 16'((i < 7) ? i : 7)) begin
                n_fail++;
                $display("FAIL move_sat step %0d x[1]=%0d moves=%0d, need %0d/%0d", i, ox[2], mcv[2], i, (i < 7) ? i : 7);
            end
        end
        cmd_valid = 1'b0;
        tick();
        n_checks++;
        if (mcv[2] !== 16'd7 || mcv[0] !== 16'd9) begin
            n_fail++; $display("FAIL move_hold moves3=%0d moves16=%0d, need 7/9", mcv[2], mcv[0]);
        end
    endtask

    task automatic test_random();
        int px, py;
        pulse_reset();
        for (int c = 0; c < 600; c++) begin
            ram_reset = ($urandom_range(0, 63) == 0);
            set_cmd(($urandom_range(0, 9) < 6),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                    4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)));
            px = $urandom_range(0, 15);
            py = $urandom_range(0, 15);
            offset_pos_x = 4'(px);
            offset_pos_y = 4'(py);
            #1;
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (rdy[k] !== (m_sweep == 0 && !ram_reset) || bsy[k] !== (m_sweep > 0) || rc[k] !== ram_reset) begin
                    n_fail++;
                    $display("FAIL rand_ctrl[%0d] cyc %0d ready=%b busy=%b rc=%b, need %b/%b/%b", k, c,
                             rdy[k], bsy[k], rc[k], (m_sweep == 0 && !ram_reset), (m_sweep > 0), ram_reset);
                end
                n_checks++;
                if (ox[k] !== 4'(mx[k][px]) || oy[k] !== 4'(my[k][py])) begin
                    n_fail++;
                    $display("FAIL rand_read[%0d] cyc %0d x[%0d]=%0d y[%0d]=%0d, need %0d/%0d", k, c,
                             px, ox[k], py, oy[k], mx[k][px], my[k][py]);
                end
                n_checks++;
                if (az[k] !== model_zero(k) || mcv[k] !== 16'(mcnt[k])) begin
                    n_fail++;
                    $display("FAIL rand_state[%0d] cyc %0d all_zero=%b moves=%0d, need %b/%0d", k, c,
                             az[k], mcv[k], model_zero(k), mcnt[k]);
                end
            end
            tick();
        end
        ram_reset = 1'b0;
        cmd_valid = 1'b0;
    endtask

    initial begin
        ram_reset = 1'b1;
        set_cmd(0, 0, 2'd0, 4'd0, 4'd0);
        offset_pos_x = 4'd0;
        offset_pos_y = 4'd0;
        test_reset();
        test_wrap();
        test_sat();
        test_clear();
        test_reset_mid_sweep();
        test_move_sat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
